dd_rom_loader: RTL and testbench

Sequencer between the HPS download stream and the DigDug ROM/PROM blocks inside the game core. It decodes each downloaded byte into one of eight fixed ROM regions and issues a registered one-hot write with a region-local address. It verifies that every region received exactly its expected byte count. It holds the core in reset until a complete, error-free image has loaded and a post-load settle delay has elapsed.

---
 rtl/dd_rom_pkg.sv | 57 +++++
 rtl/dd_rom_loader_if.sv | 22 ++
 rtl/dd_rom_region_dec.sv | 32 +++
 rtl/dd_rom_loader.sv | 123 ++++++++++++
 tb/tb_dd_rom_loader.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/dd_rom_pkg.sv
// Shared definitions for the DigDug ROM download path: region map, region and
// sequencer state enums, and lookup helpers used by the decoder and checker.
package dd_rom_pkg;

  localparam int NUM_REGIONS = 8;

  localparam logic [15:0] R0_BASE = 16'h0000, R0_SIZE = 16'd16384;
  localparam logic [15:0] R1_BASE = 16'h4000, R1_SIZE = 16'd8192;
  localparam logic [15:0] R2_BASE = 16'h6000, R2_SIZE = 16'd4096;
  localparam logic [15:0] R3_BASE = 16'h7000, R3_SIZE = 16'd2048;
  localparam logic [15:0] R4_BASE = 16'h7800, R4_SIZE = 16'd4096;
  localparam logic [15:0] R5_BASE = 16'h8800, R5_SIZE = 16'd16384;
  localparam logic [15:0] R6_BASE = 16'hC800, R6_SIZE = 16'd4096;
  localparam logic [15:0] R7_BASE = 16'hD800, R7_SIZE = 16'd1024;
  localparam logic [15:0] IMAGE_END = 16'hDC00;

  // Largest region is 16 KiB, so a 15-bit count saturating there still
  // distinguishes an overcount of every smaller region.
  localparam logic [14:0] CNT_MAX = 15'd16384;

  typedef enum logic [2:0] {
    R0_CPU0, R1_CPU1, R2_CPU2, R3_FGCHR, R4_BGCHR, R5_SPCHR, R6_BGMAP, R7_PROM
  } region_e;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_CHECK, S_HOLD, S_RUN, S_ERR
  } state_e;

  function automatic logic [15:0] region_base(input region_e r);
    case (r)
      R0_CPU0:  return R0_BASE;
      R1_CPU1:  return R1_BASE;
      R2_CPU2:  return R2_BASE;
      R3_FGCHR: return R3_BASE;
      R4_BGCHR: return R4_BASE;
      R5_SPCHR: return R5_BASE;
      R6_BGMAP: return R6_BASE;
      R7_PROM:  return R7_BASE;
      default:  return IMAGE_END;
    endcase
  endfunction

  function automatic logic [15:0] region_size(input region_e r);
    case (r)
      R0_CPU0:  return R0_SIZE;
      R1_CPU1:  return R1_SIZE;
      R2_CPU2:  return R2_SIZE;
      R3_FGCHR: return R3_SIZE;
      R4_BGCHR: return R4_SIZE;
      R5_SPCHR: return R5_SIZE;
      R6_BGMAP: return R6_SIZE;
      R7_PROM:  return R7_SIZE;
      default:  return 16'd0;
    endcase
  endfunction

endpackage

// File: rtl/dd_rom_loader_if.sv
// Download stream from the HPS plus the registered ROM write port toward the core.
interface dd_rom_loader_if #(
  parameter int ADDR_W = 25
);
  logic              dl_active;
  logic              dl_wr;
  logic [ADDR_W-1:0] dl_addr;
  logic [7:0]        dl_data;
  logic [7:0]        rom_we;
  logic [13:0]       rom_addr;
  logic [7:0]        rom_data;

  modport master (
    output dl_active, dl_wr, dl_addr, dl_data,
    input  rom_we, rom_addr, rom_data
  );

  modport slave (
    input  dl_active, dl_wr, dl_addr, dl_data,
    output rom_we, rom_addr, rom_data
  );
endinterface

// File: rtl/dd_rom_region_dec.sv
// Combinational image-address decoder: selects the owning ROM region and
// produces the region-local byte address.
module dd_rom_region_dec
  import dd_rom_pkg::*;
#(
  parameter int ADDR_W = 25
) (
  input  logic [ADDR_W-1:0] addr,
  output logic              hit,
  output logic [7:0]        sel,
  output logic [13:0]       loc_addr
);
  logic [ADDR_W-1:0] base;
  logic [ADDR_W-1:0] lim;

  always_comb begin
    hit      = 1'b0;
    sel      = '0;
    loc_addr = '0;
    base     = '0;
    lim      = '0;
    for (int i = 0; i < NUM_REGIONS; i++) begin
      base = ADDR_W'(region_base(region_e'(i)));
      lim  = base + ADDR_W'(region_size(region_e'(i)));
      if (addr >= base && addr < lim) begin
        hit      = 1'b1;
        sel[i]   = 1'b1;
        loc_addr = 14'(addr - base);
      end
    end
  end
endmodule

// File: rtl/dd_rom_loader.sv
// Download sequencer: routes HPS bytes into the eight DigDug ROM regions, checks
// per-region byte counts and holds the core in reset until a good image settles.
module dd_rom_loader
  import dd_rom_pkg::*;
#(
  parameter int HOLD_CYCLES = 1024,
  parameter int ADDR_W      = 25
) (
  input  logic           clk_sys,
  input  logic           RESET_N,
  dd_rom_loader_if.slave bus,
  output logic           core_reset,
  output logic           load_ok,
  output logic           load_err
);
  state_e      state, state_nx;
  logic        act_q, rise, fall;
  logic        accept, image_good, oor;
  logic        hit;
  logic [7:0]  sel;
  logic [13:0] loc_addr;
  logic [14:0] cnt [NUM_REGIONS];
  logic [15:0] hold_cnt;
  logic [7:0]  we_p1;
  logic [13:0] addr_p1;
  logic [7:0]  data_p1;

  dd_rom_region_dec #(.ADDR_W(ADDR_W)) u_dec (
    .addr     (bus.dl_addr),
    .hit      (hit),
    .sel      (sel),
    .loc_addr (loc_addr)
  );

  assign rise = bus.dl_active & ~act_q;
  assign fall = ~bus.dl_active & act_q;

  always_comb begin
    image_good = ~oor;
    for (int i = 0; i < NUM_REGIONS; i++)
      if (cnt[i] != 15'(region_size(region_e'(i)))) image_good = 1'b0;
  end

  always_comb begin
    state_nx   = state;
    accept     = 1'b0;
    core_reset = 1'b1;
    unique case (state)
      S_IDLE, S_ERR: state_nx = state;
      S_LOAD: begin
        accept = bus.dl_wr;
        if (fall) state_nx = S_CHECK;
      end
      S_CHECK: state_nx = image_good ? S_HOLD : S_ERR;
      S_HOLD:  if (hold_cnt == '0) state_nx = S_RUN;
      S_RUN:   core_reset = 1'b0;
      default: state_nx = S_IDLE;
    endcase
    // A new download always wins, whatever the sequencer was doing.
    if (rise) state_nx = S_LOAD;
  end

  // act_q resets high so a download already active across reset is not
  // mistaken for a fresh one.
  always_ff @(posedge clk_sys or negedge RESET_N) begin
    if (!RESET_N) begin
      state    <= S_IDLE;
      act_q    <= 1'b1;
      hold_cnt <= '0;
      load_ok  <= 1'b0;
      load_err <= 1'b0;
      oor      <= 1'b0;
    end else begin
      state <= state_nx;
      act_q <= bus.dl_active;
      if (state == S_CHECK)
        hold_cnt <= 16'(HOLD_CYCLES - 1);
      else if (state == S_HOLD && hold_cnt != '0)
        hold_cnt <= hold_cnt - 16'd1;
      if (rise) begin
        load_ok  <= 1'b0;
        load_err <= 1'b0;
        oor      <= 1'b0;
      end else begin
        if (state == S_CHECK) begin
          load_ok  <= image_good;
          load_err <= ~image_good;
        end
        if (accept && !hit) oor <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_sys or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < NUM_REGIONS; i++) cnt[i] <= '0;
    end else if (rise) begin
      for (int i = 0; i < NUM_REGIONS; i++) cnt[i] <= '0;
    end else if (accept) begin
      for (int i = 0; i < NUM_REGIONS; i++)
        if (sel[i] && cnt[i] != CNT_MAX) cnt[i] <= cnt[i] + 15'd1;
    end
  end

  // ---- stage p1: registered ROM write port ----
  always_ff @(posedge clk_sys or negedge RESET_N) begin
    if (!RESET_N) begin
      we_p1   <= '0;
      addr_p1 <= '0;
      data_p1 <= '0;
    end else begin
      we_p1 <= accept ? sel : 8'h00;
      if (accept && hit) begin
        addr_p1 <= loc_addr;
        data_p1 <= bus.dl_data;
      end
    end
  end

  assign bus.rom_we   = we_p1;
  assign bus.rom_addr = addr_p1;
  assign bus.rom_data = data_p1;
endmodule

// File: tb/tb_dd_rom_loader.sv
// Scoreboard bench for dd_rom_loader: random byte streams are checked against a
// region-map reference model; a negedge monitor compares every ROM write.
module tb_dd_rom_loader;
  localparam int AW   = 25;
  localparam int HOLD = 1024;

  logic clk_sys = 1'b0;
  logic reset_n = 1'b0;
  logic core_reset, load_ok, load_err;

  dd_rom_loader_if #(.ADDR_W(AW)) bus ();

  dd_rom_loader #(.HOLD_CYCLES(HOLD), .ADDR_W(AW)) dut (
    .clk_sys    (clk_sys),
    .RESET_N    (reset_n),
    .bus        (bus),
    .core_reset (core_reset),
    .load_ok    (load_ok),
    .load_err   (load_err)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct packed {
    logic [7:0]  we;
    logic [13:0] addr;
    logic [7:0]  data;
  } exp_t;

  exp_t exp_q[$];
  int vecs = 0;
  int errs = 0;
  int obs_cnt[8];
  int snap[8];

  // Reference region map, written straight from the published memory layout.
  int unsigned base_m[8] = '{32'h0000, 32'h4000, 32'h6000, 32'h7000,
                             32'h7800, 32'h8800, 32'hC800, 32'hD800};
  int unsigned size_m[8] = '{16384, 8192, 4096, 2048, 4096, 16384, 4096, 1024};
  int  m_cnt[8];
  bit  m_oor;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vecs++;
    if (act !== req) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic int region_of(input logic [AW-1:0] a);
    for (int i = 0; i < 8; i++)
      if (32'(a) >= base_m[i] && 32'(a) < base_m[i] + size_m[i]) return i;
    return -1;
  endfunction

  function automatic bit model_good();
    bit g = !m_oor;
    for (int i = 0; i < 8; i++) if (m_cnt[i] != int'(size_m[i])) g = 0;
    return g;
  endfunction

  always @(negedge clk_sys) begin
    exp_t e;
    if (bus.rom_we != 8'h00) begin
      for (int i = 0; i < 8; i++) if (bus.rom_we[i]) obs_cnt[i]++;
      if (exp_q.size() == 0) begin
        check("spurious_rom_we", 32'(bus.rom_we), 32'h0);
      end else begin
        e = exp_q.pop_front();
        check("rom_we",   32'(bus.rom_we),   32'(e.we));
        check("rom_addr", 32'(bus.rom_addr), 32'(e.addr));
        check("rom_data", 32'(bus.rom_data), 32'(e.data));
      end
    end
  end

  task automatic cyc();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic put(input logic [AW-1:0] a, input logic [7:0] d, input bit acc, input bit gap);
    exp_t e;
    int r;
    bus.dl_wr   = 1'b1;
    bus.dl_addr = a;
    bus.dl_data = d;
    if (acc) begin
      r = region_of(a);
      if (r < 0) m_oor = 1'b1;
      else begin
        m_cnt[r]++;
        e.we   = 8'(1 << r);
        e.addr = 14'(32'(a) - base_m[r]);
        e.data = d;
        exp_q.push_back(e);
      end
    end
    cyc();
    bus.dl_wr = 1'b0;
    if (gap && $urandom_range(0, 15) == 0) cyc();
  endtask

  task automatic start_load();
    for (int i = 0; i < 8; i++) m_cnt[i] = 0;
    m_oor = 1'b0;
    bus.dl_active = 1'b1;
    cyc();
    cyc();
  endtask

  // Last byte goes out in the same cycle dl_active drops.
  task automatic finish_load(input logic [AW-1:0] a);
    bus.dl_active = 1'b0;
    put(a, 8'($urandom), 1'b1, 1'b0);
  endtask

  task automatic check_verdict(input string tag);
    check({tag, "_load_ok"},  32'(load_ok),  32'(model_good()));
    check({tag, "_load_err"}, 32'(load_err), 32'(!model_good()));
  endtask

  task automatic check_bad_load(input string tag);
    cyc();
    check_verdict(tag);
    repeat (8) cyc();
    check({tag, "_core_reset"}, 32'(core_reset), 32'h1);
    check({tag, "_queue"}, 32'(exp_q.size()), 32'h0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_rom_we"},     32'(bus.rom_we),   32'h0);
    check({tag, "_rom_addr"},   32'(bus.rom_addr), 32'h0);
    check({tag, "_rom_data"},   32'(bus.rom_data), 32'h0);
    check({tag, "_core_reset"}, 32'(core_reset),   32'h1);
    check({tag, "_load_ok"},    32'(load_ok),      32'h0);
    check({tag, "_load_err"},   32'(load_err),     32'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [AW-1:0] a;
    bus.dl_active = 1'b0;
    bus.dl_wr     = 1'b0;
    bus.dl_addr   = '0;
    bus.dl_data   = '0;
    for (int i = 0; i < 8; i++) obs_cnt[i] = 0;
    repeat (3) cyc();
    check_reset_vals("reset");
    reset_n = 1'b1;
    cyc();

    // Writes with no download in progress must be dropped.
    for (int i = 0; i < 6; i++) put(AW'($urandom_range(0, 16'hDBFF)), 8'($urandom), 1'b0, 1'b1);
    check("idle_core_reset", 32'(core_reset), 32'h1);

    // Full image, last byte coincident with dl_active falling.
    for (int i = 0; i < 8; i++) snap[i] = obs_cnt[i];
    start_load();
    for (int ad = 0; ad < 16'hDBFF; ad++) put(AW'(ad), 8'($urandom), 1'b1, 1'b1);
    finish_load(AW'(16'hDBFF));
    n = 0;
    do begin
      cyc();
      n++;
      if (n == 1) begin
        check_verdict("full");
        check("full_load_ok_set", 32'(load_ok), 32'h1);
      end
    end while (core_reset && n < 3000);
    check("hold_cycles", 32'(n), 32'(HOLD + 1));
    for (int i = 0; i < 8; i++)
      check($sformatf("full_we_count_r%0d", i), 32'(obs_cnt[i] - snap[i]), 32'(size_m[i]));
    check("full_queue", 32'(exp_q.size()), 32'h0);
    repeat (4) cyc();
    check("run_core_reset", 32'(core_reset), 32'h0);

    // Restart from RUN, then a short random image.
    start_load();
    check("restart_core_reset", 32'(core_reset), 32'h1);
    check("restart_load_ok", 32'(load_ok), 32'h0);
    for (int i = 0; i < 60; i++) put(AW'($urandom_range(0, 16'hDBFF)), 8'($urandom), 1'b1, 1'b1);
    finish_load(AW'($urandom_range(0, 16'hDBFF)));
    check_bad_load("short");
    check("short_load_err_set", 32'(load_err), 32'h1);

    // Writes while in ERR are dropped.
    for (int i = 0; i < 4; i++) put(AW'($urandom_range(0, 16'hDBFF)), 8'($urandom), 1'b0, 1'b1);

    // Out-of-range bytes beside in-range ones.
    start_load();
    check("oor_err_cleared", 32'(load_err), 32'h0);
    for (int i = 0; i < 20; i++) put(AW'($urandom_range(16'hD800, 16'hDBFF)), 8'($urandom), 1'b1, 1'b1);
    put(AW'(16'hDC00), 8'($urandom), 1'b1, 1'b1);
    put(AW'($urandom_range(16'hDC01, 25'h1FFFFFF)), 8'($urandom), 1'b1, 1'b1);
    finish_load(AW'(16'hDBFF));
    check_bad_load("oor");

    // Asynchronous reset in the middle of a download.
    start_load();
    for (int ad = 16'h4FF0; ad < 16'h5000; ad++) put(AW'(ad), 8'($urandom), 1'b1, 1'b0);
    cyc();
    bus.dl_wr   = 1'b1;
    bus.dl_addr = AW'(16'h5000);
    bus.dl_data = 8'($urandom);
    reset_n     = 1'b0;
    #1;
    check_reset_vals("midreset");
    cyc();
    bus.dl_wr = 1'b0;
    for (int i = 1; i < 4; i++) put(AW'(16'h5000 + i), 8'($urandom), 1'b0, 1'b0);
    reset_n = 1'b1;
    for (int i = 4; i < 24; i++) put(AW'(16'h5000 + i), 8'($urandom), 1'b0, 1'b1);
    bus.dl_active = 1'b0;
    repeat (4) cyc();
    check("after_reset_core_reset", 32'(core_reset), 32'h1);
    check("after_reset_load_ok", 32'(load_ok), 32'h0);
    check("after_reset_load_err", 32'(load_err), 32'h0);

    // Fresh download after reset is accepted again.
    start_load();
    for (int i = 0; i < 10; i++) begin
      a = AW'($urandom_range(0, 16'hDBFF));
      put(a, 8'($urandom), 1'b1, 1'b1);
    end
    finish_load(AW'($urandom_range(0, 16'hDBFF)));
    check_bad_load("post_reset");

    repeat (3) cyc();
    check("final_queue", 32'(exp_q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
